multicycle_control: RTL and testbench
=====================================

# multicycle_control

Parametrised multi-cycle control unit for the RV32I core, successor to the single-cycle decoder. A Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port. It adds full RV32I integer decode (OP-IMM, shifts, SUB/SRA, all six branches, JAL, JALR, LUI, AUIPC), a memory ready handshake with timeout, and sticky trap reporting.

## Interface
- TIMEOUT_CYCLES, 15: maximum wait cycles for mem_ready per access, ≥1.
- ALU_CTRL_W, 4: alu_control width, ≥4.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- op_code  in  7  instruction opcode from the IR.
- func3  in  3  IR[14:12].
- func7  in  7  IR[31:25].
- zero, lt, ltu  in  1 each  comparator flags for A vs B: equal, signed less-than, unsigned less-than.
- mem_ready  in  1  memory has completed the current access this cycle.
- pc_write, ir_write, reg_write  out  1 each  register enables.
- adr_source  out  1  memory address: 0 = PC, 1 = alu_out.
- mem_req  out  1  memory access request.
- mem_write  out  1  write qualifier, only valid with mem_req.
- imm_type  out  3  I=000, S=001, B=010, U=011, J=100.
- alu_src_a  out  2  00 PC, 01 old_pc, 10 rs1 (A), 11 zero.
- alu_src_b  out  2  00 rs2 (B), 01 imm, 10 constant 4.
- result_source  out  2  00 alu_out, 01 mem read data, 10 live ALU result.
- alu_control  out  ALU_CTRL_W  ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9. Codes 0 to 3 are unchanged from the previous decoder.
- illegal_instr, bus_error  out  1 each  sticky trap flags.

## Operation
- States: START, FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, EXEC_U, ALU_WB, BRANCH, JALR, JAL, TRAP.
- Every output not listed for a state is 0.
- START:
  - No outputs asserted.
  - Goes to FETCH after one cycle.
- FETCH:
  - Asserts mem_req with adr_source=0.
  - ALU computes PC+4 as a=00, b=10, ADD, result_source=10.
  - On mem_ready: asserts ir_write and pc_write, then goes to DECODE. Otherwise holds.
- DECODE:
  - ALU computes old_pc+imm (a=01, b=01, ADD) into alu_out; this is the branch/JAL target.
  - Next state by opcode: 0000011 or 0100011 → MEM_ADR; 0110011 → EXEC_R; 0010011 → EXEC_I; 0110111 or 0010111 → EXEC_U; 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR.
  - Any other opcode, or an illegal func field, → TRAP with illegal_instr set.
- MEM_ADR:
  - ALU computes rs1+imm (a=10, b=01, ADD).
  - Load → MEM_RD; store → MEM_WR.
- MEM_RD:
  - Asserts mem_req with adr_source=1.
  - On mem_ready → MEM_WB.
- MEM_WB:
  - Asserts reg_write with result_source=01.
  - → FETCH.
- MEM_WR:
  - Asserts mem_req and mem_write with adr_source=1.
  - On mem_ready → FETCH.
- EXEC_R: a=10, b=00, alu_control from func3/func7, → ALU_WB.
- EXEC_I: a=10, b=01, alu_control from func3 (func7 used only for shifts), → ALU_WB.
- EXEC_U: a=11 for LUI or 01 for AUIPC, b=01, ADD, → ALU_WB.
- ALU_WB:
  - Asserts reg_write with result_source=00.
  - → FETCH.
- BRANCH:
  - ALU does SUB with a=10, b=00.
  - Asserts pc_write with result_source=00 only when the branch is taken:
    - BEQ zero; BNE !zero.
    - BLT lt; BGE !lt.
    - BLTU ltu; BGEU !ltu.
  - → FETCH. func3 010 and 011 are illegal.
- JALR: rs1+imm → alu_out (a=10, b=01, ADD), → JAL.
- JAL:
  - Asserts pc_write with result_source=00, loading the target from alu_out.
  - ALU computes old_pc+4 (a=01, b=10, ADD) into alu_out.
  - → ALU_WB.
- Legal func7 values:
  - R-type: 0000000 everywhere; 0100000 also allowed for ADD→SUB and SRL→SRA.
  - OP-IMM: SLLI needs func7=0000000; SRLI/SRAI accept 0000000 or 0100000.
  - Anything else is illegal.
- TRAP:
  - All enables are 0; the state holds until rst.
  - illegal_instr or bus_error stays 1 while in TRAP.

## Timing
- All outputs are 0 during reset and in START; the FSM is in START after rst falls.
- Decode uses the IR value, which is valid from DECODE onward.
- Instruction latency, with zero-wait memory:
  - Branch: 3 cycles.
  - R-type, I-type, U-type: 4 cycles.
  - Store: 4 cycles.
  - JAL: 4 cycles; JALR: 5 cycles.
  - Load: 5 cycles.
- Each wait cycle adds 1.
- Timeout counter:
  - Increments on every cycle with mem_req=1 and mem_ready=0.
  - Clears on mem_ready and on any state change.
  - When the count reaches TIMEOUT_CYCLES without mem_ready, the next state is TRAP with bus_error.
  - mem_ready arriving in that same cycle wins: normal completion.
- mem_ready while mem_req=0 is ignored.
- rst mid-access drops mem_req asynchronously and clears the counter and flags.

## Structure
- Package control_pkg holds:
  - The state enum and the alu_control codes.
  - The opcode constants.
  - The imm_type and src-select encodings.
- Sub-module alu_decoder is combinational. It maps alu_op, func3 and func7 to alu_control and an illegal flag.

## Test plan
- Reset, then ADD x3,x1,x2 (0x002081B3) with zero-wait memory: states START, FETCH, DECODE, EXEC_R, ALU_WB, FETCH. reg_write is high for exactly 1 cycle and alu_control=0.
- SUB (func7=0100000) → alu_control=1. SRAI → 9. SLLI with func7=0100000 → illegal_instr=1, state TRAP.
- BNE with zero=1 → no pc_write. BLTU with ltu=1 → pc_write=1 for 1 cycle, result_source=00.
- LW with mem_ready delayed 3 cycles in MEM_RD → total 8 cycles, reg_write with result_source=01.
- With TIMEOUT_CYCLES=4 and mem_ready held low in FETCH → bus_error=1 after 4 waits. Repeat with mem_ready arriving on the 4th cycle → normal DECODE.
- JALR → JALR, JAL, ALU_WB. pc_write is high in JAL only. rst asserted mid-JAL → all outputs 0 immediately.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// Holds the FSM state enum, ALU control codes, ALU decoder operation class,
// the RV32I opcode constants, the imm_type / source-select encodings, the
// registered-output bundle, and a helper that picks the immediate format
// from the opcode.
package control_pkg;

  typedef enum logic [3:0] {
    S_START, S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC_R, S_EXEC_I, S_EXEC_U, S_ALU_WB, S_BRANCH, S_JALR, S_JAL, S_TRAP
  } state_e;

  // Codes 0..3 are kept identical to the single-cycle decoder.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_SUB  = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR  = 4'd4, ALU_SLT  = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
    ALU_SRL  = 4'd8, ALU_SRA  = 4'd9
  } alu_ctrl_e;

  // Operation class handed to the ALU decoder.
  typedef enum logic [1:0] {
    ALUOP_ADD, ALUOP_SUB, ALUOP_R, ALUOP_I
  } alu_op_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Outputs that depend only on the state are registered as one bundle.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_source;
    logic       reg_write;
    logic       pc_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_source;
    alu_ctrl_e  alu_ctrl;
  } ctrl_out_t;

  function automatic logic [2:0] imm_fmt(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_LUI, OP_AUIPC: return IMM_U;
      OP_JAL:           return IMM_J;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle control unit and its datapath/memory.
// master: the control unit (reads IR fields, flags, mem_ready; drives enables,
//         selects, alu_control and trap flags).
// slave:  the datapath/memory side.
interface multicycle_control_if #(parameter int ALU_CTRL_W = 4);
  logic [6:0]            op_code;
  logic [2:0]            func3;
  logic [6:0]            func7;
  logic                  zero, lt, ltu;
  logic                  mem_ready;
  logic                  pc_write, ir_write, reg_write;
  logic                  adr_source, mem_req, mem_write;
  logic [2:0]            imm_type;
  logic [1:0]            alu_src_a, alu_src_b, result_source;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  illegal_instr, bus_error;

  modport master (
    input  op_code, func3, func7, zero, lt, ltu, mem_ready,
    output pc_write, ir_write, reg_write, adr_source, mem_req, mem_write,
           imm_type, alu_src_a, alu_src_b, result_source, alu_control,
           illegal_instr, bus_error
  );

  modport slave (
    output op_code, func3, func7, zero, lt, ltu, mem_ready,
    input  pc_write, ir_write, reg_write, adr_source, mem_req, mem_write,
           imm_type, alu_src_a, alu_src_b, result_source, alu_control,
           illegal_instr, bus_error
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU decoder.
// Inputs:  alu_op (ADD / SUB / R-type / OP-IMM class), func3, func7.
// Outputs: alu_ctrl (ALU operation code), illegal (func7 not legal for the
//          R-type or OP-IMM encoding).
module alu_decoder
  import control_pkg::*;
(
  input  alu_op_e     alu_op,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  output alu_ctrl_e   alu_ctrl,
  output logic        illegal
);
  logic f7_base, f7_alt;
  assign f7_base = (func7 == F7_BASE);
  assign f7_alt  = (func7 == F7_ALT);

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      default: begin
        // R-type and OP-IMM share the func3 map; only R-type turns ADD into SUB
        // (for OP-IMM func7 is immediate bits except on shifts).
        case (func3)
          3'b000:  alu_ctrl = (alu_op == ALUOP_R && f7_alt) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = f7_alt ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
        if (alu_op == ALUOP_R)
          illegal = !(f7_base || (f7_alt && (func3 == 3'b000 || func3 == 3'b101)));
        else
          illegal = (func3 == 3'b001 && !f7_base) ||
                    (func3 == 3'b101 && !(f7_base || f7_alt));
      end
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit (Moore FSM sharing one ALU and one memory port).
// Ports: clk, rst (async, active-high); bus (master modport) carrying the IR
// fields, comparator flags, mem_ready handshake, register enables, address /
// ALU / result selects, alu_control and the sticky illegal_instr / bus_error.
// State-only outputs are registered from the next state, so they are 0 in
// reset and drop asynchronously with rst. ir_write / pc_write qualified by
// mem_ready or the branch condition, and imm_type (a decode of the IR), are
// combinational from the current state.
module multicycle_control
  import control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int ALU_CTRL_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  ctrl_out_t        out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;

  alu_op_e   dec_op;
  alu_ctrl_e dec_ctrl;
  logic      dec_illegal;
  logic      mem_done, timed_out, taken, uses_imm;

  always_comb begin
    case (bus.op_code)
      OP_R:      dec_op = ALUOP_R;
      OP_IMM:    dec_op = ALUOP_I;
      OP_BRANCH: dec_op = ALUOP_SUB;
      default:   dec_op = ALUOP_ADD;
    endcase
  end

  alu_decoder u_alu_dec (
    .alu_op   (dec_op),
    .func3    (bus.func3),
    .func7    (bus.func7),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_illegal)
  );

  // mem_ready only counts while a request is outstanding; on the last allowed
  // wait cycle a ready still wins over the timeout.
  assign mem_done  = out_q.mem_req & bus.mem_ready;
  assign timed_out = out_q.mem_req & ~bus.mem_ready & (cnt_q == CNT_LAST);

  always_comb begin
    case (bus.func3)
      3'b000:  taken = bus.zero;
      3'b001:  taken = ~bus.zero;
      3'b100:  taken = bus.lt;
      3'b101:  taken = ~bus.lt;
      3'b110:  taken = bus.ltu;
      3'b111:  taken = ~bus.ltu;
      default: taken = 1'b0;
    endcase
  end

  // Next state and sticky flags.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (mem_done) begin
          case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_MEM_RD: state_d = S_MEM_WB;
            default:  state_d = S_FETCH;
          endcase
        end else if (timed_out) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        case (bus.op_code)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
          OP_R:              state_d = S_EXEC_R;
          OP_IMM:            state_d = S_EXEC_I;
          OP_LUI, OP_AUIPC:  state_d = S_EXEC_U;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          default:           state_d = S_TRAP;
        endcase
        if (((bus.op_code == OP_R || bus.op_code == OP_IMM) && dec_illegal) ||
            (bus.op_code == OP_BRANCH && bus.func3[2:1] == 2'b01))
          state_d = S_TRAP;
        if (state_d == S_TRAP)
          illegal_d = 1'b1;
      end
      S_MEM_ADR: state_d = (bus.op_code == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_WB, S_ALU_WB, S_BRANCH: state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_EXEC_U, S_JAL: state_d = S_ALU_WB;
      S_JALR:  state_d = S_JAL;
      default: state_d = S_TRAP;
    endcase
  end

  // Wait counter restarts on any state change and on mem_ready.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q || bus.mem_ready)
      cnt_d = '0;
    else if (out_q.mem_req)
      cnt_d = cnt_q + 1'b1;
  end

  // Registered outputs for the state being entered. IR-dependent fields are
  // only used for states entered from DECODE or later, where the IR is valid.
  always_comb begin
    out_d          = '0;
    out_d.alu_ctrl = ALU_ADD;
    case (state_d)
      S_FETCH: begin
        out_d.mem_req       = 1'b1;
        out_d.alu_src_a     = SRCA_PC;
        out_d.alu_src_b     = SRCB_FOUR;
        out_d.result_source = RES_ALU;
      end
      S_DECODE: begin
        out_d.alu_src_a = SRCA_OLDPC;
        out_d.alu_src_b = SRCB_IMM;
      end
      S_MEM_ADR, S_JALR: begin
        out_d.alu_src_a = SRCA_RS1;
        out_d.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        out_d.mem_req    = 1'b1;
        out_d.adr_source = 1'b1;
      end
      S_MEM_WB: begin
        out_d.reg_write     = 1'b1;
        out_d.result_source = RES_MEM;
      end
      S_MEM_WR: begin
        out_d.mem_req    = 1'b1;
        out_d.mem_write  = 1'b1;
        out_d.adr_source = 1'b1;
      end
      S_EXEC_R: begin
        out_d.alu_src_a = SRCA_RS1;
        out_d.alu_src_b = SRCB_RS2;
        out_d.alu_ctrl  = dec_ctrl;
      end
      S_EXEC_I: begin
        out_d.alu_src_a = SRCA_RS1;
        out_d.alu_src_b = SRCB_IMM;
        out_d.alu_ctrl  = dec_ctrl;
      end
      S_EXEC_U: begin
        out_d.alu_src_a = (bus.op_code == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        out_d.alu_src_b = SRCB_IMM;
      end
      S_ALU_WB: begin
        out_d.reg_write     = 1'b1;
        out_d.result_source = RES_ALUOUT;
      end
      S_BRANCH: begin
        out_d.alu_src_a = SRCA_RS1;
        out_d.alu_src_b = SRCB_RS2;
        out_d.alu_ctrl  = ALU_SUB;
      end
      S_JAL: begin
        out_d.pc_write  = 1'b1;
        out_d.alu_src_a = SRCA_OLDPC;
        out_d.alu_src_b = SRCB_FOUR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_START;
      out_q     <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign uses_imm = (state_q == S_DECODE) || (state_q == S_MEM_ADR) ||
                    (state_q == S_EXEC_I) || (state_q == S_EXEC_U)  ||
                    (state_q == S_JALR);

  assign bus.pc_write      = out_q.pc_write | ((state_q == S_FETCH) & mem_done) |
                             ((state_q == S_BRANCH) & taken);
  assign bus.ir_write      = (state_q == S_FETCH) & mem_done;
  assign bus.reg_write     = out_q.reg_write;
  assign bus.adr_source    = out_q.adr_source;
  assign bus.mem_req       = out_q.mem_req;
  assign bus.mem_write     = out_q.mem_write;
  assign bus.imm_type      = uses_imm ? imm_fmt(bus.op_code) : IMM_I;
  assign bus.alu_src_a     = out_q.alu_src_a;
  assign bus.alu_src_b     = out_q.alu_src_b;
  assign bus.result_source = out_q.result_source;
  assign bus.alu_control   = ALU_CTRL_W'(out_q.alu_ctrl);
  assign bus.illegal_instr = illegal_q;
  assign bus.bus_error     = bus_err_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed steps plus random instructions, each
// instruction checked against an ISA-level model (latency, write counts,
// execute-stage ALU op, immediate format, trap behaviour).
module tb_multicycle_control;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_if #(.ALU_CTRL_W(4)) bus ();
  multicycle_control #(.TIMEOUT_CYCLES(TO), .ALU_CTRL_W(4)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int wait_q[$];
  int wait_left = -1;
  int max_wait = 0;
  logic [6:0] ops [10] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h17,
                           7'h63, 7'h6f, 7'h67, 7'h7f};

  typedef struct {
    bit ill; int lat; int regw; int rs; int pcw; int memw;
    int alu; int srca; int imm;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] all_outs();
    return {bus.pc_write, bus.ir_write, bus.reg_write, bus.adr_source, bus.mem_req,
            bus.mem_write, bus.imm_type, bus.alu_src_a, bus.alu_src_b,
            bus.result_source, bus.alu_control, bus.illegal_instr, bus.bus_error};
  endfunction

  function automatic int next_wait();
    if (wait_q.size() > 0) return wait_q.pop_front();
    return int'($urandom_range(0, max_wait));
  endfunction

  // RV32I rules: which encodings are legal, how long each class takes with
  // zero-wait memory, what it writes and which ALU op its execute step uses.
  function automatic exp_t model(bit [6:0] op, bit [2:0] f3, bit [6:0] f7, bit z, bit l, bit lu);
    int   r_alu [8];
    exp_t e;
    bit   alt, base, tk;
    r_alu = '{0, 7, 5, 6, 4, 8, 3, 2};   // ADD SLL SLT SLTU XOR SRL OR AND
    alt   = (f7 == 7'h20);
    base  = (f7 == 7'h00);
    e = '{ill: 0, lat: 4, regw: 1, rs: 0, pcw: 1, memw: 0, alu: 0, srca: 2, imm: 0};
    case (op)
      7'h03: begin e.lat = 5; e.rs = 1; end
      7'h23: begin e.regw = 0; e.memw = 1; e.imm = 1; end
      7'h33: begin
        e.ill = !(base || (alt && (f3 == 0 || f3 == 5)));
        e.alu = r_alu[f3] + int'(alt && (f3 == 0 || f3 == 5));
      end
      7'h13: begin
        e.ill = (f3 == 1 && !base) || (f3 == 5 && !(base || alt));
        e.alu = r_alu[f3] + int'(alt && f3 == 5);
      end
      7'h37: begin e.srca = 3; e.imm = 3; end
      7'h17: begin e.srca = 1; e.imm = 3; end
      7'h63: begin
        e.lat = 3; e.regw = 0; e.alu = 1; e.imm = 2;
        e.ill = (f3 == 2 || f3 == 3);
        case (f3)
          0: tk = z;   1: tk = !z;
          4: tk = l;   5: tk = !l;
          6: tk = lu;  default: tk = !lu;
        endcase
        e.pcw = 1 + int'(tk);
      end
      7'h6f: begin e.pcw = 2; e.srca = 1; e.imm = 4; end
      7'h67: begin e.lat = 5; e.pcw = 2; end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  // Ends at the negedge of a FETCH cycle whose mem_ready is not yet driven.
  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    wait_left = -1;
    repeat (2) @(negedge clk);
    #1 chk("reset outputs", 32'(all_outs()), 0);
    rst = 1'b0;
    #1 chk("start outputs", 32'(all_outs()), 0);
    @(negedge clk);
    chk("fetch after start", 32'(bus.mem_req), 1);
  endtask

  // Runs one instruction from its FETCH cycle up to the next FETCH (or TRAP).
  task automatic run_instr(input bit [6:0] op, input bit [2:0] f3, input bit [6:0] f7,
                           input bit z, input bit l, input bit lu, input string tag,
                           output int cyc);
    exp_t e;
    int waits, regw, rs_seen, pcw, memw, irw, post, alu_seen, srca_seen, imm_seen;
    bit done, trapped;
    e = model(op, f3, f7, z, l, lu);
    cyc = 0; waits = 0; regw = 0; rs_seen = -1; pcw = 0; memw = 0; irw = 0;
    post = -1; alu_seen = -1; srca_seen = -1; imm_seen = -1; done = 0; trapped = 0;
    bus.op_code = op; bus.func3 = f3; bus.func7 = f7;
    bus.zero = z; bus.lt = l; bus.ltu = lu;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (irw > 0 && bus.mem_req && !bus.adr_source) begin done = 1; break; end
      end
      if (bus.mem_req) begin
        if (wait_left < 0) wait_left = next_wait();
        if (wait_left > 0) begin bus.mem_ready = 1'b0; wait_left--; end
        else begin bus.mem_ready = 1'b1; wait_left = -1; end
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      cyc++;
      if (bus.mem_req && !bus.mem_ready) waits++;
      if (bus.ir_write) begin irw++; post = 0; end
      else if (post >= 0) post++;
      if (bus.reg_write) begin regw++; rs_seen = int'(bus.result_source); end
      pcw  += int'(bus.pc_write);
      memw += int'(bus.mem_write && bus.mem_ready);
      if (post == 1) imm_seen = int'(bus.imm_type);
      if (post == 2) begin alu_seen = int'(bus.alu_control); srca_seen = int'(bus.alu_src_a); end
      if (bus.illegal_instr) begin trapped = 1; break; end
    end
    chk({tag, " trap"}, 32'(trapped), 32'(e.ill));
    if (trapped) begin
      chk({tag, " trap latency"}, cyc, 3 + waits);
      repeat (2) @(negedge clk);
      #1 chk({tag, " trap holds"}, 32'({bus.illegal_instr, bus.mem_req, bus.reg_write, bus.pc_write}), 32'b1000);
      do_reset();
    end else begin
      chk({tag, " completed"}, 32'(done), 1);
      chk({tag, " latency"}, cyc, e.lat + waits);
      chk({tag, " ir_write cycles"}, irw, 1);
      chk({tag, " reg_write cycles"}, regw, e.regw);
      if (e.regw > 0) chk({tag, " result_source"}, rs_seen, e.rs);
      chk({tag, " pc_write cycles"}, pcw, e.pcw);
      chk({tag, " store cycles"}, memw, e.memw);
      chk({tag, " exec alu_control"}, alu_seen, e.alu);
      chk({tag, " exec alu_src_a"}, srca_seen, e.srca);
      chk({tag, " decode imm_type"}, imm_seen, e.imm);
    end
  endtask

  initial begin
    int cyc;
    bit [6:0] f7;
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.op_code = '0; bus.func3 = '0; bus.func7 = '0;
    bus.zero = 1'b0; bus.lt = 1'b0; bus.ltu = 1'b0;

    // Directed: zero-wait memory.
    do_reset();
    run_instr(7'h33, 3'd0, 7'h00, 0, 0, 0, "add x3,x1,x2", cyc);
    chk("add total cycles", cyc, 4);
    run_instr(7'h33, 3'd0, 7'h20, 0, 0, 0, "sub", cyc);
    run_instr(7'h13, 3'd5, 7'h20, 0, 0, 0, "srai", cyc);
    run_instr(7'h13, 3'd1, 7'h20, 0, 0, 0, "slli func7 bad", cyc);
    run_instr(7'h63, 3'd1, 7'h00, 1, 0, 0, "bne not taken", cyc);
    run_instr(7'h63, 3'd6, 7'h00, 0, 0, 1, "bltu taken", cyc);
    chk("bltu total cycles", cyc, 3);

    // Load with three wait cycles in MEM_RD.
    wait_q.push_back(0);
    wait_q.push_back(3);
    run_instr(7'h03, 3'd2, 7'h00, 0, 0, 0, "lw wait3", cyc);
    chk("lw total cycles", cyc, 8);

    // Timeout: mem_ready stays low through FETCH.
    do_reset();
    bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("no bus_error before limit", 32'({bus.bus_error, bus.mem_req}), 32'b01);
    @(negedge clk);
    #1 chk("bus_error at limit", 32'({bus.bus_error, bus.mem_req, bus.illegal_instr}), 32'b100);
    repeat (3) @(negedge clk);
    #1 chk("bus_error sticky", 32'({bus.bus_error, bus.mem_req, bus.ir_write}), 32'b100);

    // Ready arriving on the last allowed cycle completes normally.
    do_reset();
    wait_q.push_back(3);
    run_instr(7'h33, 3'd7, 7'h00, 0, 0, 0, "ready on 4th", cyc);
    chk("ready on 4th cycles", cyc, 7);
    chk("ready on 4th no bus_error", 32'(bus.bus_error), 0);

    // JALR, then reset in the middle of JAL.
    run_instr(7'h67, 3'd0, 7'h00, 0, 0, 0, "jalr", cyc);
    bus.op_code = 7'h67;
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("jal pc_write", 32'({bus.pc_write, bus.result_source, bus.alu_src_a}), 32'b10001);
    rst = 1'b1;
    #1 chk("rst mid-jal outputs", 32'(all_outs()), 0);
    do_reset();

    // Random instructions with random memory waits.
    max_wait = 2;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    f7 = 7'h00;
        2:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      run_instr(ops[$urandom_range(0, 9)], 3'($urandom), f7,
                1'($urandom), 1'($urandom), 1'($urandom),
                $sformatf("rnd%0d", i), cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
